game_tick_gen: RTL and testbench
================================

GAME_TICK_GEN -- requirements
Module: game_tick_gen

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 5000000, clocks per tick at level 0.
REQ-002 SHALL have parameter CNT_W, default 24, period counter width.
REQ-003 SHALL have parameter SPEED_W, default 2, speed input width.
REQ-004 SHALL have parameter MAX_SPEED, default 3, highest speed level.
REQ-005 SHALL have parameter TCNT_W, default 16, tick counter width.
REQ-006 SHALL have parameter SLOW_DIV, default 4, ticks per oSlowTick.
REQ-007 SHALL have parameter LEVEL_UP_TICKS, default 32, ticks per automatic speed step (used only with the Configuration feature).
REQ-008 SHALL have port iClock  input  1  clock, all logic on rising edge.
REQ-009 SHALL have port iReset  input  1  reset, synchronous, active-low.
REQ-010 SHALL have port iSpeed  input  SPEED_W  requested speed level.
REQ-011 SHALL have port iPause  input  1  freeze tick generation while high.
REQ-012 SHALL have port iRestart  input  1  synchronous soft restart, active-high.
REQ-013 SHALL have port oTick  output  1  one-cycle tick pulse.
REQ-014 SHALL have port oSlowTick  output  1  one-cycle pulse on every SLOW_DIV-th tick.
REQ-015 SHALL have port oTickCount  output  TCNT_W  ticks since reset or restart.
REQ-016 SHALL have port oSpeedActive  output  SPEED_W  speed level of the current interval.

Function
REQ-017 SHALL derive the period as P = BASE_PERIOD >> L, where L is the effective level.
REQ-018 SHALL clamp the requested level: iSpeed > MAX_SPEED is treated as MAX_SPEED.
REQ-019 SHALL decrement the period counter by 1 per cycle while iPause is low, and hold it while iPause is high.
REQ-020 SHALL define a tick event as a cycle with counter == 0 and iPause low.
REQ-021 On a tick event, SHALL reload the counter with P-1 and register oTick = 1 for the next cycle only; otherwise oTick = 0.
REQ-022 SHALL space tick events P cycles apart when unpaused; pause cycles extend the interval one-for-one.
REQ-023 SHALL sample L only at reload; a speed change mid-interval SHALL NOT alter the running interval.
REQ-024 SHALL update oSpeedActive with the L used at each reload.
REQ-025 SHALL increment oTickCount on each tick event, wrapping from 2^TCNT_W-1 to 0; the new value SHALL be visible in the same cycle oTick is high.
REQ-026 SHALL assert oSlowTick coincident with oTick on every SLOW_DIV-th tick (ticks SLOW_DIV, 2*SLOW_DIV, ...).
REQ-027 When iRestart is high, SHALL perform the reset actions of REQ-030 regardless of iPause.
REQ-028 When iRestart and iReset are both active, iReset SHALL take priority (identical result).
REQ-029 SHALL require BASE_PERIOD >> MAX_SPEED >= 2 and BASE_PERIOD < 2^CNT_W; violating values are unsupported.

Reset
REQ-030 While iReset is low, SHALL set counter = (BASE_PERIOD >> clamp(iSpeed)) - 1, oTick = 0, oSlowTick = 0, oTickCount = 0, slow divider = 0, auto level = 0, and oSpeedActive = clamp(iSpeed).
REQ-031 The first oTick SHALL be high in the cycle after the P-th rising edge following reset release, with no pause in between.

Configuration
REQ-032 With macro GAME_TICK_AUTOSPEED_EN defined, SHALL keep an auto level that increments every LEVEL_UP_TICKS ticks, saturating at MAX_SPEED; L SHALL equal min(clamp(iSpeed) + auto level, MAX_SPEED).
REQ-033 Without GAME_TICK_AUTOSPEED_EN, SHALL omit the auto-level logic, with L = clamp(iSpeed) and LEVEL_UP_TICKS ignored.

Verification
REQ-034 SHALL cover: BASE_PERIOD=16, iSpeed=0, reset release -> oTick high after edge 16, then every 16 cycles; oSlowTick on ticks 4 and 8.
REQ-035 SHALL cover: iSpeed changed 0->2 mid-interval -> current interval stays 16 cycles, next intervals 4 cycles, oSpeedActive=2 from the reload.
REQ-036 SHALL cover: iPause high for 5 cycles mid-interval -> that interval is 21 cycles, counter frozen, no oTick while paused at counter 0.
REQ-037 SHALL cover: TCNT_W=4, 17 ticks -> oTickCount wraps 15->0->1; iRestart after 3 ticks -> oTickCount=0 and the next tick arrives a full P later.
REQ-038 SHALL cover: GAME_TICK_AUTOSPEED_EN, LEVEL_UP_TICKS=2, MAX_SPEED=3, iSpeed=0 -> intervals 16,16,8,8,4,4,2,2,2...; iSpeed=3 -> saturates at 2 cycles.

Source files
------------

// File: rtl/game_tick_gen.sv
`default_nettype none
// ==========================================================================
// game_tick_gen : speed-scaled game tick, slow tick and tick counter.
// Optional auto speed-up when GAME_TICK_AUTOSPEED_EN is defined.  Rev 1.0
// ==========================================================================
module game_tick_gen #(
    parameter int BASE_PERIOD    = 5000000,
    parameter int CNT_W          = 24,
    parameter int SPEED_W        = 2,
    parameter int MAX_SPEED      = 3,
    parameter int TCNT_W         = 16,
    parameter int SLOW_DIV       = 4,
    parameter int LEVEL_UP_TICKS = 32
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic [SPEED_W-1:0] iSpeed,
    input  logic               iPause,
    input  logic               iRestart,
    output logic               oTick,
    output logic               oSlowTick,
    output logic [TCNT_W-1:0]  oTickCount,
    output logic [SPEED_W-1:0] oSpeedActive
);

    localparam int                 SDIV_W      = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [CNT_W-1:0]   C_BASE      = CNT_W'(BASE_PERIOD);
    localparam logic [SPEED_W-1:0] C_MAX_LVL   = SPEED_W'(MAX_SPEED);
    localparam logic [SDIV_W-1:0]  C_SDIV_LAST = SDIV_W'(SLOW_DIV - 1);

    if (((BASE_PERIOD >> MAX_SPEED) < 2) || ((BASE_PERIOD >> CNT_W) != 0) ||
        (SLOW_DIV < 1) || (LEVEL_UP_TICKS < 1) || (MAX_SPEED >= (1 << SPEED_W)))
    begin : g_param_check
        $error("game_tick_gen: unsupported parameter combination");
    end

    logic [CNT_W-1:0]   count;
    logic [SDIV_W-1:0]  slow_cnt;
    logic [SPEED_W-1:0] req_level;
    logic [SPEED_W-1:0] next_level;
    logic [SPEED_W-1:0] load_level;
    logic [CNT_W-1:0]   load_val;
    logic               restart;
    logic               tick_event;

    // Hard reset and soft restart perform identical actions.
    assign restart    = !iReset || iRestart;
    assign tick_event = (count == '0) && !iPause;
    assign req_level  = (32'(iSpeed) > 32'(MAX_SPEED)) ? C_MAX_LVL : iSpeed;

`ifdef GAME_TICK_AUTOSPEED_EN
    localparam int              UP_W      = (LEVEL_UP_TICKS > 1) ? $clog2(LEVEL_UP_TICKS) : 1;
    localparam logic [UP_W-1:0] C_UP_LAST = UP_W'(LEVEL_UP_TICKS - 1);

    logic [UP_W-1:0]    up_cnt;
    logic [SPEED_W-1:0] auto_level;
    logic [SPEED_W-1:0] auto_next;
    logic [SPEED_W:0]   level_sum;

    // The reload on the level-up tick already uses the raised auto level.
    always_comb begin
        auto_next = auto_level;
        if (tick_event && (up_cnt == C_UP_LAST) && (auto_level < C_MAX_LVL)) begin
            auto_next = auto_level + 1'b1;
        end
    end

    assign level_sum  = {1'b0, req_level} + {1'b0, auto_next};
    assign next_level = (level_sum > {1'b0, C_MAX_LVL}) ? C_MAX_LVL : level_sum[SPEED_W-1:0];

    always_ff @(posedge iClock) begin
        if (restart) begin
            up_cnt     <= '0;
            auto_level <= '0;
        end else if (tick_event) begin
            up_cnt     <= (up_cnt == C_UP_LAST) ? '0 : up_cnt + 1'b1;
            auto_level <= auto_next;
        end
    end
`else
    assign next_level = req_level;
`endif

    // One shifter serves both the reset load and the tick reload.
    assign load_level = restart ? req_level : next_level;
    assign load_val   = (C_BASE >> load_level) - 1'b1;

    always_ff @(posedge iClock) begin
        if (restart) begin
            count        <= load_val;
            oTick        <= 1'b0;
            oSlowTick    <= 1'b0;
            oTickCount   <= '0;
            slow_cnt     <= '0;
            oSpeedActive <= req_level;
        end else begin
            oTick     <= tick_event;
            oSlowTick <= tick_event && (slow_cnt == C_SDIV_LAST);
            if (tick_event) begin
                count        <= load_val;
                oTickCount   <= oTickCount + 1'b1;
                slow_cnt     <= (slow_cnt == C_SDIV_LAST) ? '0 : slow_cnt + 1'b1;
                oSpeedActive <= next_level;
            end else if (!iPause) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// tb_game_tick_gen : directed and random checks of game_tick_gen against an interval-level model.
module tb_game_tick_gen;

    localparam int BASE_PERIOD    = 16;
    localparam int CNT_W          = 8;
    localparam int SPEED_W        = 2;
    localparam int MAX_SPEED      = 3;
    localparam int TCNT_W         = 4;
    localparam int SLOW_DIV       = 4;
    localparam int LEVEL_UP_TICKS = 2;

    logic               iClock   = 1'b0;
    logic               iReset   = 1'b0;
    logic [SPEED_W-1:0] iSpeed   = '0;
    logic               iPause   = 1'b0;
    logic               iRestart = 1'b0;
    logic               oTick;
    logic               oSlowTick;
    logic [TCNT_W-1:0]  oTickCount;
    logic [SPEED_W-1:0] oSpeedActive;

    game_tick_gen #(
        .BASE_PERIOD    (BASE_PERIOD),
        .CNT_W          (CNT_W),
        .SPEED_W        (SPEED_W),
        .MAX_SPEED      (MAX_SPEED),
        .TCNT_W         (TCNT_W),
        .SLOW_DIV       (SLOW_DIV),
        .LEVEL_UP_TICKS (LEVEL_UP_TICKS)
    ) dut (
        .iClock       (iClock),
        .iReset       (iReset),
        .iSpeed       (iSpeed),
        .iPause       (iPause),
        .iRestart     (iRestart),
        .oTick        (oTick),
        .oSlowTick    (oSlowTick),
        .oTickCount   (oTickCount),
        .oSpeedActive (oSpeedActive)
    );

    always #5 iClock = ~iClock;

    int checks = 0;
    int errors = 0;

    // Model state: interval length, unpaused cycles elapsed in it, ticks since (re)start.
    int   m_elapsed = 0;
    int   m_period  = BASE_PERIOD;
    int   m_ticks   = 0;
    int   m_level   = 0;
    logic exp_tick  = 1'b0;
    logic exp_slow  = 1'b0;

    function automatic int clamp_lvl(input int s);
        return (s > MAX_SPEED) ? MAX_SPEED : s;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int auto_lvl;
        exp_tick = 1'b0;
        exp_slow = 1'b0;
        if (!iReset || iRestart) begin
            m_ticks   = 0;
            m_elapsed = 0;
            m_level   = clamp_lvl(int'(iSpeed));
            m_period  = BASE_PERIOD >> m_level;
        end else if (!iPause) begin
            m_elapsed++;
            if (m_elapsed == m_period) begin
                m_ticks++;
                exp_tick = 1'b1;
                exp_slow = ((m_ticks % SLOW_DIV) == 0);
                auto_lvl = 0;
`ifdef GAME_TICK_AUTOSPEED_EN
                auto_lvl = min2(m_ticks / LEVEL_UP_TICKS, MAX_SPEED);
`endif
                m_level   = min2(clamp_lvl(int'(iSpeed)) + auto_lvl, MAX_SPEED);
                m_period  = BASE_PERIOD >> m_level;
                m_elapsed = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge iClock);
        model_edge();
        #1;
        check("tick", 32'(oTick), 32'(exp_tick));
        check("slow_tick", 32'(oSlowTick), 32'(exp_slow));
        check("tick_count", 32'(oTickCount), m_ticks % (1 << TCNT_W));
        check("speed_active", 32'(oSpeedActive), m_level);
    endtask

    task automatic run_until_tick(input int max_cycles, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!oTick && (n < max_cycles));
        check("tick_wait", 32'(oTick), 32'd1);
    endtask

    initial begin
        int n;
        repeat (3) step();
        check("reset_count", 32'(oTickCount), 32'd0);
        check("reset_speed", 32'(oSpeedActive), 32'd0);
        check("reset_tick", 32'(oTick), 32'd0);
        iReset = 1'b1;

`ifndef GAME_TICK_AUTOSPEED_EN
        run_until_tick(40, n);
        check("first_interval", n, 16);
        for (int i = 2; i <= 8; i++) begin
            run_until_tick(40, n);
            check("interval_l0", n, 16);
            check("slow_on_tick", 32'(oSlowTick), 32'((i % 4) == 0));
        end

        // Speed request changes mid-interval: current interval keeps its length.
        repeat (5) step();
        iSpeed = SPEED_W'(2);
        run_until_tick(40, n);
        check("interval_before_speedup", n + 5, 16);
        check("speed_at_reload", 32'(oSpeedActive), 32'd2);
        repeat (2) begin
            run_until_tick(40, n);
            check("interval_l2", n, 4);
        end
        iSpeed = SPEED_W'(0);
        run_until_tick(40, n);
        check("interval_l2_last", n, 4);

        // Pause mid-interval, then pause while the counter sits at zero.
        repeat (3) step();
        iPause = 1'b1;
        repeat (5) step();
        iPause = 1'b0;
        run_until_tick(40, n);
        check("paused_interval", n + 8, 21);
        repeat (15) step();
        iPause = 1'b1;
        repeat (4) begin
            step();
            check("no_tick_paused", 32'(oTick), 32'd0);
        end
        iPause = 1'b0;
        step();
        check("tick_after_unpause", 32'(oTick), 32'd1);

        for (int i = 15; i <= 17; i++) begin
            run_until_tick(40, n);
            check("wrap_count", 32'(oTickCount), i % 16);
        end

        repeat (5) step();
        iRestart = 1'b1;
        step();
        check("restart_count", 32'(oTickCount), 32'd0);
        iRestart = 1'b0;
        run_until_tick(40, n);
        check("interval_after_restart", n, 16);
        check("count_after_restart", 32'(oTickCount), 32'd1);
`else
        begin : auto_seq
            int exp_iv [9] = '{16, 16, 8, 8, 4, 4, 2, 2, 2};
            for (int i = 0; i < 9; i++) begin
                run_until_tick(40, n);
                check("auto_interval", n, exp_iv[i]);
            end
            iSpeed   = SPEED_W'(3);
            iRestart = 1'b1;
            step();
            iRestart = 1'b0;
            check("restart_speed3", 32'(oSpeedActive), 32'd3);
            repeat (4) begin
                run_until_tick(40, n);
                check("auto_interval_sat", n, 2);
            end
        end
`endif

        for (int c = 0; c < 3000; c++) begin
            iSpeed   = SPEED_W'($urandom_range(0, 3));
            iPause   = ($urandom_range(0, 7) == 0);
            iRestart = ($urandom_range(0, 199) == 0);
            iReset   = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
